v8_trigger_ctrl: RTL and testbench
==================================

# v8_trigger_ctrl

Sequencing and event-capture controller for the v8 shaping filter. It holds the filter in reset until enabled, waits out the filter settling time, and arms a threshold trigger on the filter output. It then tracks each pulse to its peak and hands amplitude plus timestamp downstream over a valid/ready handshake, applying dead time and counting pile-up crossings.

## Interface
- SIZE_FILTER_DATA, 16: width of filter output samples and threshold.
- TS_WIDTH, 32: timestamp counter width.
- SETTLE_CYCLES, 32: cycles spent in SETTLE after filter reset release; must be ≥ filter pipeline depth (k+l+6).
- DEAD_CYCLES, 16: dead-time cycles after each accepted event.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  run request; level-sensitive.
- threshold  in  SIZE_FILTER_DATA  unsigned trigger level; sampled every cycle.
- filt_data  in  SIZE_FILTER_DATA  unsigned filter output sample, one per clk.
- filt_rst_n  out  1  active-low reset to the filter; 0 in IDLE, 1 otherwise.
- evt_valid  out  1  event available.
- evt_ready  in  1  downstream accepts event.
- evt_amp  out  SIZE_FILTER_DATA  peak amplitude of event.
- evt_ts  out  TS_WIDTH  timestamp of the peak sample.
- pileup_cnt  out  16  saturating count of rejected threshold crossings.
- state_o  out  3  current FSM state encoding, for debug.

## Operation
- States: IDLE=0, SETTLE=1, ARMED=2, PEAK=3, EMIT=4, DEAD=5, WAIT_LOW=6.
- ts: free-running counter, +1 every cycle from reset (including IDLE); wraps modulo 2^TS_WIDTH.
- above = (filt_data > threshold), strictly greater; above_q = above delayed one cycle (reset 0).
- IDLE: filt_rst_n=0. If enable=1, go to SETTLE and load settle counter with 0.
- SETTLE: counter increments; after SETTLE_CYCLES cycles in SETTLE, go to ARMED.
- ARMED: if above=1, go to PEAK; load max <= filt_data and ts_cap <= ts.
- PEAK: if filt_data > max, update max and ts_cap. If filt_data < max, latch evt_amp <= max, evt_ts <= ts_cap, and go to EMIT. If equal, stay; ts_cap keeps the first sample of the plateau.
- EMIT: evt_valid=1. Stays until evt_ready=1; the transfer occurs on the cycle where valid&ready are both high, then go to DEAD with the dead counter cleared.
- DEAD: count DEAD_CYCLES cycles, then go to ARMED if above=0, else to WAIT_LOW.
- WAIT_LOW: go to ARMED on the first cycle above=0.
- Pile-up: in EMIT, DEAD and WAIT_LOW, each rising edge of above (above=1 & above_q=0) increments pileup_cnt; saturates at 0xFFFF.
- enable=0: from SETTLE, ARMED, PEAK, DEAD or WAIT_LOW, go to IDLE next cycle; a PEAK in progress is discarded. In EMIT, the handshake completes first, then go to IDLE instead of DEAD.
- Entering IDLE re-asserts filt_rst_n=0; re-enable always re-runs the full SETTLE.
- evt_amp and evt_ts hold their value while evt_valid=1 and change only on entry to EMIT.

## Timing
- Reset values: state IDLE, filt_rst_n=0, evt_valid=0, evt_amp=0, evt_ts=0, pileup_cnt=0, ts=0, state_o=0.
- Reset wins over all other inputs, in every state, including mid-handshake. evt_valid drops the cycle after reset is sampled.
- enable sampled high in IDLE at edge N: filt_rst_n=1 from N+1, state ARMED from N+1+SETTLE_CYCLES.
- Trigger: first sample with above=1 in ARMED at edge N puts state PEAK from N+1.
- Event: first sample below max at edge N asserts evt_valid from N+1. Minimum latency from peak sample to evt_valid is 2 cycles.
- Dead time: the handshake at edge N puts state DEAD from N+1 and ARMED or WAIT_LOW from N+1+DEAD_CYCLES.
- evt_ready=1 while evt_valid=0 has no effect.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Startup: SETTLE_CYCLES=32, reset then enable=1 at edge 0 → filt_rst_n=1 at cycle 1, state_o=2 at cycle 33; filt_data=500 during SETTLE produces no event.
- Single pulse: threshold=100, filt_data 50,120,180,200,190,0 with evt_ready=1 → one event, evt_amp=200, evt_ts = ts of the 200 sample, evt_valid high exactly one cycle, starting the cycle after 190.
- Backpressure and plateau: pulse 120,300,300,250 with evt_ready=0 for 10 cycles → evt_valid held with evt_amp=300 and evt_ts of the first 300 stable for 10 cycles; transfer on the cycle ready rises.
- Pile-up: DEAD_CYCLES=16, a second pulse crossing 100 eight cycles after the handshake → pileup_cnt=1, no second event; if still above at dead-time end → WAIT_LOW, then ARMED once below.
- Abort: enable=0 during PEAK → IDLE next cycle, filt_rst_n=0, no event. enable=0 during EMIT with ready=0 → event still delivered, then IDLE.
- Reset mid-EMIT and counter wraps: reset=1 while evt_valid=1 → all outputs at reset values the next cycle. Force pileup_cnt to 0xFFFF → stays 0xFFFF. TS_WIDTH=4 → evt_ts wraps 15→0 correctly.

Source files
------------

// File: rtl/v8_trigger_ctrl.sv
// Sequencing / event-capture controller for the v8 shaping filter: settle, arm, peak-track,
// emit amplitude+timestamp over valid/ready, then dead time with pile-up counting.
module v8_trigger_ctrl #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_WIDTH         = 32,
  parameter int SETTLE_CYCLES    = 32,
  parameter int DEAD_CYCLES      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  input  logic [SIZE_FILTER_DATA-1:0] filt_data,
  output logic                        filt_rst_n,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [SIZE_FILTER_DATA-1:0] evt_amp,
  output logic [TS_WIDTH-1:0]         evt_ts,
  output logic [15:0]                 pileup_cnt,
  output logic [2:0]                  state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_ARMED    = 3'd2,
    S_PEAK     = 3'd3,
    S_EMIT     = 3'd4,
    S_DEAD     = 3'd5,
    S_WAIT_LOW = 3'd6
  } state_t;

  localparam int MAX_CNT = (SETTLE_CYCLES > DEAD_CYCLES) ? SETTLE_CYCLES : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_t                      r_state;
  state_t                      w_next_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [TS_WIDTH-1:0]         r_ts;
  logic [TS_WIDTH-1:0]         r_ts_cap;
  logic [SIZE_FILTER_DATA-1:0] r_max;
  logic [SIZE_FILTER_DATA-1:0] r_evt_amp;
  logic [TS_WIDTH-1:0]         r_evt_ts;
  logic [15:0]                 r_pileup_cnt;
  logic                        r_above_q;
  logic                        w_above;
  logic                        w_settle_done;
  logic                        w_dead_done;
  logic                        w_cnt_clr;
  logic                        w_peak_ld;
  logic                        w_evt_ld;
  logic                        w_pile_evt;

  assign w_above       = (filt_data > threshold);
  assign w_settle_done = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_dead_done   = (r_cnt == CNT_W'(DEAD_CYCLES - 1));
  // Only a fresh crossing counts; a pulse still above threshold is not a new pile-up.
  assign w_pile_evt    = (r_state == S_EMIT || r_state == S_DEAD || r_state == S_WAIT_LOW)
                         && w_above && !r_above_q;

  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_peak_ld    = 1'b0;
    w_evt_ld     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next_state = S_SETTLE;
          w_cnt_clr    = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!enable)            w_next_state = S_IDLE;
        else if (w_settle_done) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        if (!enable) w_next_state = S_IDLE;
        else if (w_above) begin
          w_next_state = S_PEAK;
          w_peak_ld    = 1'b1;
        end
      end
      S_PEAK: begin
        if (!enable) w_next_state = S_IDLE;
        else if (filt_data > r_max) w_peak_ld = 1'b1;
        else if (filt_data < r_max) begin
          w_next_state = S_EMIT;
          w_evt_ld     = 1'b1;
        end
      end
      S_EMIT: begin
        // The pending event is always delivered; enable only picks where we go afterwards.
        if (evt_ready) begin
          w_next_state = enable ? S_DEAD : S_IDLE;
          w_cnt_clr    = 1'b1;
        end
      end
      S_DEAD: begin
        if (!enable)          w_next_state = S_IDLE;
        else if (w_dead_done) w_next_state = w_above ? S_WAIT_LOW : S_ARMED;
      end
      S_WAIT_LOW: begin
        if (!enable)      w_next_state = S_IDLE;
        else if (!w_above) w_next_state = S_ARMED;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ts         <= '0;
      r_ts_cap     <= '0;
      r_max        <= '0;
      r_evt_amp    <= '0;
      r_evt_ts     <= '0;
      r_pileup_cnt <= '0;
      r_above_q    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ts      <= r_ts + TS_WIDTH'(1);
      r_above_q <= w_above;
      if (w_cnt_clr)                                  r_cnt <= '0;
      else if (r_state == S_SETTLE || r_state == S_DEAD) r_cnt <= r_cnt + CNT_W'(1);
      if (w_peak_ld) begin
        r_max    <= filt_data;
        r_ts_cap <= r_ts;
      end
      if (w_evt_ld) begin
        r_evt_amp <= r_max;
        r_evt_ts  <= r_ts_cap;
      end
      if (w_pile_evt && r_pileup_cnt != 16'hFFFF) r_pileup_cnt <= r_pileup_cnt + 16'd1;
    end
  end

  assign filt_rst_n = (r_state != S_IDLE);
  assign evt_valid  = (r_state == S_EMIT);
  assign evt_amp    = r_evt_amp;
  assign evt_ts     = r_evt_ts;
  assign pileup_cnt = r_pileup_cnt;
  assign state_o    = r_state;

endmodule

// File: tb/tb_v8_trigger_ctrl.sv
// Directed bench for v8_trigger_ctrl; events are scoreboarded, a 4-bit-timestamp twin checks wrap.
`timescale 1ns/1ps
module tb_v8_trigger_ctrl;
  localparam int DW = 16;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          reset, enable, evt_ready;
  logic [DW-1:0] threshold, filt_data;
  logic          filt_rst_n, evt_valid;
  logic [DW-1:0] evt_amp;
  logic [TW-1:0] evt_ts;
  logic [15:0]   pileup_cnt;
  logic [2:0]    state_o;
  logic          filt_rst_n4, evt_valid4;
  logic [DW-1:0] evt_amp4;
  logic [3:0]    evt_ts4;
  logic [15:0]   pileup_cnt4;
  logic [2:0]    state_o4;

  typedef struct packed {
    logic [DW-1:0] amp;
    logic [TW-1:0] ts;
  } evt_t;

  evt_t          sb[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  logic [TW-1:0] tb_ts;
  logic [TW-1:0] exp_ts;

  v8_trigger_ctrl #(.SIZE_FILTER_DATA(DW), .TS_WIDTH(TW), .SETTLE_CYCLES(32), .DEAD_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .filt_data(filt_data),
    .filt_rst_n(filt_rst_n), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_amp(evt_amp),
    .evt_ts(evt_ts), .pileup_cnt(pileup_cnt), .state_o(state_o));

  v8_trigger_ctrl #(.SIZE_FILTER_DATA(DW), .TS_WIDTH(4), .SETTLE_CYCLES(32), .DEAD_CYCLES(16)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .filt_data(filt_data),
    .filt_rst_n(filt_rst_n4), .evt_valid(evt_valid4), .evt_ready(evt_ready), .evt_amp(evt_amp4),
    .evt_ts(evt_ts4), .pileup_cnt(pileup_cnt4), .state_o(state_o4));

  always #5 clk = ~clk;

  // Reference timestamp: counts edges since reset was last sampled.
  always @(posedge clk) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; they are sampled at the following edge.
  task automatic step(input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    filt_data = d;
  endtask

  // Called right after driving the peak sample: the DUT stamps it with the current ts.
  task automatic push_evt(input logic [DW-1:0] a);
    evt_t e;
    e.amp  = a;
    e.ts   = tb_ts;
    exp_ts = tb_ts;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state_o), 0);
    check({tag, "_rst_n"}, 32'(filt_rst_n), 0);
    check({tag, "_valid"}, 32'(evt_valid), 0);
    check({tag, "_amp"}, 32'(evt_amp), 0);
    check({tag, "_ts"}, evt_ts, 0);
    check({tag, "_pileup"}, 32'(pileup_cnt), 0);
    check({tag, "_ts4"}, 32'(evt_ts4), 0);
  endtask

  // A transfer happens at the next edge whenever valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed event amp 0x%0h, expected no event", evt_amp);
      end
      if (sb.size() > 0) begin
        evt_t e;
        e = sb.pop_front();
        check("sb_amp", 32'(evt_amp), 32'(e.amp));
        check("sb_ts", evt_ts, e.ts);
        check("sb_ts4_wrap", 32'(evt_ts4), 32'(e.ts[3:0]));
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; evt_ready = 1'b1; threshold = 16'd100; filt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    check("reset_state4", 32'(state_o4), 0);
    check("reset_rst_n4", 32'(filt_rst_n4), 0);
    check("reset_valid4", 32'(evt_valid4), 0);
    check("reset_amp4", 32'(evt_amp4), 0);
    check("reset_pileup4", 32'(pileup_cnt4), 0);

    // Startup: large samples during SETTLE must not trigger.
    @(posedge clk); #1; reset = 1'b0; enable = 1'b1; filt_data = 16'd500;
    @(posedge clk); @(negedge clk);
    check("startup_state", 32'(state_o), 1);
    check("startup_rst_n", 32'(filt_rst_n), 1);
    repeat (30) @(posedge clk);
    #1; filt_data = '0;
    @(posedge clk); @(negedge clk);
    check("settle_last", 32'(state_o), 1);
    @(posedge clk); @(negedge clk);
    check("settle_armed", 32'(state_o), 2);

    // Single pulse with ready held high.
    step(16'd50); step(16'd120); step(16'd180); step(16'd200); push_evt(16'd200);
    step(16'd190); step(16'd0);
    @(negedge clk);
    check("pulse_valid", 32'(evt_valid), 1);
    step(16'd0);
    @(negedge clk);
    check("pulse_valid_1cyc", 32'(evt_valid), 0);
    check("pulse_dead", 32'(state_o), 5);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("dead_hold", 32'(state_o), 5);
    @(posedge clk); @(negedge clk);
    check("dead_exit", 32'(state_o), 2);

    // Backpressure with a plateau: first 300 sample owns the timestamp.
    step(16'd120); evt_ready = 1'b0;
    step(16'd300); push_evt(16'd300);
    step(16'd300); step(16'd250); step(16'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(evt_valid), 1);
      check("bp_amp", 32'(evt_amp), 300);
      check("bp_ts", evt_ts, exp_ts);
      @(posedge clk); #1;
    end
    evt_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_dead", 32'(state_o), 5);

    // Pile-up: crossing 8 cycles after the handshake, still high when dead time ends.
    repeat (7) @(posedge clk);
    #1; filt_data = 16'd150;
    @(posedge clk); @(negedge clk);
    check("pile_cnt", 32'(pileup_cnt), 1);
    check("pile_in_dead", 32'(state_o), 5);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pile_dead_hold", 32'(state_o), 5);
    @(posedge clk); @(negedge clk);
    check("pile_wait_low", 32'(state_o), 6);
    step(16'd0);
    @(posedge clk); @(negedge clk);
    check("pile_rearmed", 32'(state_o), 2);
    check("pile_cnt_hold", 32'(pileup_cnt), 1);

    // Abort during PEAK: the falling sample arrives with enable low and is discarded.
    step(16'd150); step(16'd200);
    @(negedge clk);
    check("abort_peak", 32'(state_o), 3);
    @(posedge clk); #1; enable = 1'b0; filt_data = 16'd50;
    @(posedge clk); @(negedge clk);
    check("abort_idle", 32'(state_o), 0);
    check("abort_rst_n", 32'(filt_rst_n), 0);
    check("abort_valid", 32'(evt_valid), 0);

    // Re-enable re-runs the full settle time.
    @(posedge clk); #1; enable = 1'b1; filt_data = '0;
    @(posedge clk); @(negedge clk);
    check("reen_settle", 32'(state_o), 1);
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("reen_armed", 32'(state_o), 2);

    // Disable while EMIT is stalled: event still delivered, then IDLE.
    step(16'd200); push_evt(16'd200); evt_ready = 1'b0;
    step(16'd150); step(16'd0); enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("emit_dis_valid", 32'(evt_valid), 1);
    check("emit_dis_state", 32'(state_o), 4);
    @(posedge clk); #1; evt_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("emit_dis_idle", 32'(state_o), 0);
    check("emit_dis_rst_n", 32'(filt_rst_n), 0);

    // Reset while an event is pending.
    @(posedge clk); #1; enable = 1'b1; evt_ready = 1'b0;
    @(posedge clk);
    repeat (32) @(posedge clk);
    #1;
    step(16'd300); push_evt(16'd300); step(16'd100); step(16'd0);
    @(negedge clk);
    check("rst_emit_valid", 32'(evt_valid), 1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_vals("rst_emit");
    void'(sb.pop_front());

    // Saturation of the pile-up counter.
    @(posedge clk); #1; reset = 1'b0; evt_ready = 1'b1;
    @(posedge clk);
    repeat (32) @(posedge clk);
    #1;
    step(16'd180); push_evt(16'd180); step(16'd90); step(16'd0);
    @(posedge clk); @(negedge clk);
    check("sat_dead", 32'(state_o), 5);
    force dut.r_pileup_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_pileup_cnt;
    @(posedge clk); #1; filt_data = 16'd150;
    @(posedge clk); @(negedge clk);
    check("sat_pileup", 32'(pileup_cnt), 32'hFFFF);
    check("sat_ref_cnt", 32'(pileup_cnt4), 1);

    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
